// File: rtl/hex_page_display.sv
// hex_page_display: multiplexed common-anode seven-segment viewer for one byte
// of a TX or RX buffer. Shows the byte, the hex page index and a t/r glyph.
// Paging uses debounced buttons with hold-to-repeat. A per-page "new RX data"
// flag lights the decimal point on the mode digit.

// One button: two-flop synchroniser, counter debounce, rising-edge press pulse.
// After reset the button is blocked until it has been seen released for a full
// debounce window, so a press held through reset never produces an event.
module hex_page_display_btn #(
  parameter int unsigned CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int unsigned   CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          db_q, db_d, dbp_q, dbp_d;
  logic          blk_q, blk_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Sync chain; the counter runs only while the synced level differs from the
  // accepted one (or, while blocked, while the button reads released).
  always_comb begin
    s1_d  = btn_i;
    s2_d  = s1_q;
    dbp_d = db_q;
    db_d  = db_q;
    blk_d = blk_q;
    cnt_d = '0;
    if (blk_q) begin
      if (!s2_q) begin
        if (cnt_q == CMAX) blk_d = 1'b0;
        else               cnt_d = cnt_q + CW'(1);
      end
    end else if (s2_q != db_q) begin
      if (cnt_q == CMAX) db_d  = s2_q;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset leaves the button blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      dbp_q <= 1'b0;
      blk_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      db_q  <= db_d;
      dbp_q <= dbp_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = db_q;
  assign press_o = db_q & ~dbp_q;
endmodule

module hex_page_display #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  localparam int unsigned PW             = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  left,
  input  logic                  right,
  input  logic                  switch_memory,
  input  logic [DEPTH*8-1:0]    TXBUF,
  input  logic [DEPTH*8-1:0]    RXBUF,
  input  logic                  rx_wr,
  input  logic [PW-1:0]         rx_wr_idx,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [PW-1:0]         page,
  output logic                  memory
);
  localparam int unsigned PG        = (PW + 3) / 4;
  localparam int unsigned MODE_SLOT = 2 + PG;
  localparam int unsigned SW        = $clog2(NUM_DIGITS);
  localparam int unsigned DVW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned RW        = $clog2(REPEAT_DELAY + 1);

  localparam logic [DVW-1:0] DVMAX   = DVW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]  SLAST   = SW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0]  SMODE   = SW'(MODE_SLOT);
  localparam logic [RW-1:0]  RMAX    = RW'(REPEAT_DELAY);
  // After a repeat step the counter is pulled back so the next one lands
  // REPEAT_RATE cycles later (assumes REPEAT_RATE <= REPEAT_DELAY).
  localparam logic [RW-1:0]  RRELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);

  localparam logic [0:6] G_BLANK = 7'b1111111;
  localparam logic [0:6] G_T     = 7'b1110000;
  localparam logic [0:6] G_R     = 7'b1111010;

  function automatic logic [0:6] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Buttons: bit 0 = left, 1 = right, 2 = switch_memory.
  logic [2:0] lvl, prs;
  logic       unused_sw_lvl;

  hex_page_display_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_btn [2:0] (
    .clk     (clk),
    .rst     (rst),
    .btn_i   ({switch_memory, right, left}),
    .level_o (lvl),
    .press_o (prs)
  );

  assign unused_sw_lvl = lvl[2];

  logic [1:0][RW-1:0]    rep_q, rep_d;
  logic [1:0]            elig, rep_step;
  logic [PW-1:0]         page_q, page_d;
  logic                  mem_q, mem_d;
  logic [DEPTH-1:0]      flags_q, flags_d;
  logic                  arr_q, arr_d;
  logic                  new_q, new_d;
  logic                  inc, dec, chg, hit;
  logic [DVW-1:0]        div_q, div_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [0:6]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic [7:0]            byte_sel;
  logic [4*PG-1:0]       pg_ext;

  // Auto-repeat: counts held cycles from the press; only one direction held.
  always_comb begin
    rep_d    = rep_q;
    rep_step = '0;
    elig[0]  = lvl[0] & ~lvl[1];
    elig[1]  = lvl[1] & ~lvl[0];
    for (int i = 0; i < 2; i++) begin
      rep_step[i] = elig[i] && (rep_q[i] == RMAX);
      if (!elig[i])         rep_d[i] = '0;
      else if (rep_step[i]) rep_d[i] = RRELOAD;
      else                  rep_d[i] = rep_q[i] + RW'(1);
    end
  end

  // Page/memory stepping and new-data flag bookkeeping.
  always_comb begin
    inc    = prs[1] | rep_step[1];
    dec    = prs[0] | rep_step[0];
    page_d = page_q;
    if (inc && !dec)      page_d = page_q + PW'(1);
    else if (dec && !inc) page_d = page_q - PW'(1);
    mem_d = mem_q ^ prs[2];
    chg   = (page_d != page_q) || (mem_d != mem_q);
    // arr_q marks the first cycle a page is on screen in RX mode.
    arr_d = chg && mem_d;
    // A write to the page being shown is seen immediately; it lights dp
    // without leaving a flag behind.
    hit     = rx_wr && mem_q && (rx_wr_idx == page_q) && !chg;
    flags_d = flags_q;
    if (arr_q)          flags_d[page_q]    = 1'b0;
    if (rx_wr && !hit)  flags_d[rx_wr_idx] = 1'b1;
    new_d = new_q;
    if (chg)        new_d = 1'b0;
    else if (arr_q) new_d = flags_q[page_q] | hit;
    else if (hit)   new_d = 1'b1;
  end

  // Digit slot sequencing and the glyph/enable for the current slot.
  always_comb begin
    div_d  = div_q + DVW'(1);
    slot_d = slot_q;
    if (div_q == DVMAX) begin
      div_d  = '0;
      slot_d = (slot_q == SLAST) ? '0 : slot_q + SW'(1);
    end
    byte_sel = mem_q ? RXBUF[{page_q, 3'b000} +: 8] : TXBUF[{page_q, 3'b000} +: 8];
    pg_ext          = '0;
    pg_ext[PW-1:0]  = page_q;
    seg_d = G_BLANK;
    an_d  = '1;
    dp_d  = 1'b1;
    if (slot_q == SW'(0)) seg_d = hex7(byte_sel[3:0]);
    if (slot_q == SW'(1)) seg_d = hex7(byte_sel[7:4]);
    for (int i = 0; i < PG; i++)
      if (slot_q == SW'(2 + i)) seg_d = hex7(pg_ext[4*i +: 4]);
    if (slot_q == SMODE) begin
      seg_d = mem_q ? G_R : G_T;
      dp_d  = ~(mem_q & new_q);
    end
    if (slot_q <= SMODE) an_d = ~(NUM_DIGITS'(1) << slot_q);
  end

  // All state; seg/an/dp are registered together so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q   <= '0;
      page_q  <= '0;
      mem_q   <= 1'b0;
      flags_q <= '0;
      arr_q   <= 1'b0;
      new_q   <= 1'b0;
      div_q   <= '0;
      slot_q  <= '0;
      seg_q   <= G_BLANK;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      page_q  <= page_d;
      mem_q   <= mem_d;
      flags_q <= flags_d;
      arr_q   <= arr_d;
      new_q   <= new_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign dp     = dp_q;
  assign page   = page_q;
  assign memory = mem_q;
endmodule

// File: tb/tb_hex_page_display.sv
// Directed bench for hex_page_display with small timing parameters.
module tb_hex_page_display;
  localparam int ND = 6, DPT = 4, RDIV = 4, DB = 3, RPD = 20, RPR = 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic        left = 1'b0, right = 1'b0, switch_memory = 1'b0;
  logic [31:0] txbuf = 32'h332211A5;
  logic [31:0] rxbuf = 32'h5BC37E19;
  logic        rx_wr = 1'b0;
  logic [1:0]  rx_wr_idx = 2'd0;
  logic [0:6]  seg;
  logic [5:0]  an;
  logic        dp;
  logic [1:0]  page;
  logic        memory;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  hex_page_display #(
    .NUM_DIGITS(ND), .DEPTH(DPT), .REFRESH_DIV(RDIV), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RPD), .REPEAT_RATE(RPR)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .switch_memory(switch_memory),
    .TXBUF(txbuf), .RXBUF(rxbuf), .rx_wr(rx_wr), .rx_wr_idx(rx_wr_idx),
    .seg(seg), .an(an), .dp(dp), .page(page), .memory(memory)
  );

  localparam logic [6:0] G_BLANK = 7'b1111111, G_T = 7'b1110000, G_R = 7'b1111010;

  typedef struct {
    logic [7:0] b;
    logic [6:0] lo;
    logic [6:0] hi;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Wait for a fresh start of the given lit slot, bounded.
  task automatic wait_slot(input int s);
    logic [5:0] tgt;
    int n;
    tgt = ~(6'd1 << s);
    n = 0;
    tick(1);
    while (an == tgt && n < 100) begin tick(1); n++; end
    while (an != tgt && n < 100) begin tick(1); n++; end
    if (n >= 100) chk("slot_timeout", 32'(an), 32'(tgt));
  endtask

  // mask bits: 0 left, 1 right, 2 switch_memory.
  task automatic press(input logic [2:0] mask, input int hold);
    {switch_memory, right, left} = mask;
    tick(hold);
    {switch_memory, right, left} = 3'b000;
    tick(12);
  endtask

  initial begin
    int steps;
    logic [1:0] prev;

    vecs[0] = '{8'hA5, 7'b0100100, 7'b0001000};
    vecs[1] = '{8'h3C, 7'b0110001, 7'b0000110};
    vecs[2] = '{8'hF0, 7'b0000001, 7'b0111000};
    vecs[3] = '{8'h81, 7'b1001111, 7'b0000000};
    vecs[4] = '{8'h6E, 7'b0110000, 7'b0100000};
    vecs[5] = '{8'hD2, 7'b0010010, 7'b1000010};
    vecs[6] = '{8'h49, 7'b0000100, 7'b1001100};
    vecs[7] = '{8'hB7, 7'b0001111, 7'b1100000};

    // Reset state
    tick(3);
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_seg", 32'(seg), 32'(G_BLANK));
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_page", 32'(page), 32'h0);
    chk("rst_mem", 32'(memory), 32'h0);

    // Slot sequence from the first cycle after reset
    rst = 1'b0;
    tick(1);
    chk("s0_an", 32'(an), 32'h3E);
    chk("s0_seg", 32'(seg), 32'(7'b0100100));
    chk("s0_dp", 32'(dp), 32'h1);
    tick(4);
    chk("s1_an", 32'(an), 32'h3D);
    chk("s1_seg", 32'(seg), 32'(7'b0001000));
    tick(4);
    chk("s2_an", 32'(an), 32'h3B);
    chk("s2_seg", 32'(seg), 32'(7'b0000001));
    tick(4);
    chk("s3_an", 32'(an), 32'h37);
    chk("s3_seg", 32'(seg), 32'(G_T));
    chk("s3_dp", 32'(dp), 32'h1);
    tick(4);
    chk("s4_seg", 32'(seg), 32'(G_BLANK));
    tick(4);
    chk("s5_seg", 32'(seg), 32'(G_BLANK));
    tick(4);
    chk("wrap_an", 32'(an), 32'h3E);

    // Byte glyph table, read live from TX entry 0
    for (int i = 0; i < 8; i++) begin
      txbuf[7:0] = vecs[i].b;
      wait_slot(0);
      chk($sformatf("vec%0d_lo", i), 32'(seg), 32'(vecs[i].lo));
      wait_slot(1);
      chk($sformatf("vec%0d_hi", i), 32'(seg), 32'(vecs[i].hi));
    end
    txbuf[7:0] = 8'hA5;

    // Press latency: input sampled at edge k, page moves at edge k+DB+3
    right = 1'b1;
    tick(6);
    chk("lat_before", 32'(page), 32'h0);
    tick(1);
    chk("lat_after", 32'(page), 32'h1);
    tick(4);
    right = 1'b0;
    tick(12);
    chk("after_hold11", 32'(page), 32'h1);

    press(3'b010, 6); chk("right2", 32'(page), 32'h2);
    press(3'b010, 6); chk("right3", 32'(page), 32'h3);
    wait_slot(2);
    chk("pgdig3", 32'(seg), 32'(7'b0000110));
    press(3'b010, 6); chk("right_wrap", 32'(page), 32'h0);
    press(3'b001, 6); chk("left_wrap", 32'(page), 32'h3);
    press(3'b010, 6); chk("right_back0", 32'(page), 32'h0);

    // Short glitch
    right = 1'b1;
    tick(2);
    right = 1'b0;
    tick(12);
    chk("glitch", 32'(page), 32'h0);

    // Auto-repeat: steps at held cycles 0,20,25,30,35
    steps = 0;
    prev = page;
    right = 1'b1;
    for (int i = 0; i < 38; i++) begin
      tick(1);
      if (page != prev) begin steps++; prev = page; end
    end
    right = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (page != prev) begin steps++; prev = page; end
    end
    chk("rep_steps", 32'(steps), 32'd5);
    chk("rep_page", 32'(page), 32'h1);

    // Left and right together cancel; neither repeats
    press(3'b011, 30);
    chk("lr_cancel", 32'(page), 32'h1);

    // switch_memory and right together both apply
    press(3'b110, 6);
    chk("sw_r_mem", 32'(memory), 32'h1);
    chk("sw_r_page", 32'(page), 32'h2);
    wait_slot(3);
    chk("mode_r", 32'(seg), 32'(G_R));
    chk("mode_r_dp", 32'(dp), 32'h1);
    press(3'b100, 6);
    chk("sw_back", 32'(memory), 32'h0);

    // New-data flag
    press(3'b001, 6);
    press(3'b001, 6);
    chk("flag_pg0", 32'(page), 32'h0);
    rx_wr = 1'b1; rx_wr_idx = 2'd2;
    tick(1);
    rx_wr = 1'b0;
    press(3'b100, 6);
    wait_slot(3);
    chk("flag_p0_dp", 32'(dp), 32'h1);
    press(3'b010, 6);
    press(3'b010, 6);
    wait_slot(3);
    chk("flag_p2_dp", 32'(dp), 32'h0);
    wait_slot(0);
    chk("rx2_lo", 32'(seg), 32'(7'b0000110));
    wait_slot(1);
    chk("rx2_hi", 32'(seg), 32'(7'b0110001));
    press(3'b010, 6);
    wait_slot(3);
    chk("flag_p3_dp", 32'(dp), 32'h1);
    press(3'b001, 6);
    wait_slot(3);
    chk("flag_ret_dp", 32'(dp), 32'h1);
    rx_wr = 1'b1; rx_wr_idx = 2'd2;
    tick(1);
    rx_wr = 1'b0;
    wait_slot(3);
    chk("flag_live_dp", 32'(dp), 32'h0);

    // Reset during a held press
    right = 1'b1;
    tick(10);
    chk("pre_rst_page", 32'(page), 32'h3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_page", 32'(page), 32'h0);
    chk("mid_rst_mem", 32'(memory), 32'h0);
    tick(40);
    chk("held_after_rst", 32'(page), 32'h0);
    right = 1'b0;
    tick(12);
    press(3'b010, 6);
    chk("repress", 32'(page), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
